// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the program counter and keeps at most one instruction-memory request in flight.
// Handles variable memory latency, redirects from execute, downstream stall and halt.
// The fetched instruction and its PC go to the fetch-to-decode register. flush_out
// clears that register on the same edge that a redirect is taken.

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        halted,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic        fetch_valid,
  output logic        flush_out
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StValid,
    StDrop,
    StHalt
  } state_e;

  state_e      state;
  logic [31:0] pc;
  logic        halt_pending;

  logic        redirect_take;
  logic [31:0] redirect_target;
  logic        unused_redirect_bits;

  // Halt wins over a redirect; a redirect wins over stall.
  assign redirect_take        = redirect_valid & ~halted;
  assign redirect_target      = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign flush_out = redirect_take;
  assign imem_addr = pc;

  // Fetch FSM. imem_req and the decode-side outputs are registered together with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= StIdle;
      pc              <= RESET_PC;
      imem_req        <= 1'b0;
      instruction_out <= 32'h0;
      pc_out          <= 32'h0;
      fetch_valid     <= 1'b0;
      halt_pending    <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (halted) begin
            state <= StHalt;
          end else begin
            if (redirect_take) pc <= redirect_target;
            state    <= StReq;
            imem_req <= 1'b1;
          end
        end

        StReq: begin
          if (halted) begin
            imem_req <= 1'b0;
            if (imem_ready) begin
              // The request was accepted, so its response must still be drained.
              halt_pending <= 1'b1;
              state        <= StDrop;
            end else begin
              state <= StHalt;
            end
          end else if (redirect_take) begin
            pc <= redirect_target;
            if (imem_ready) begin
              // The old address was accepted; its response is now stale.
              imem_req <= 1'b0;
              state    <= StDrop;
            end
          end else if (imem_ready) begin
            imem_req <= 1'b0;
            state    <= StWait;
          end
        end

        StWait: begin
          if (halted) begin
            if (imem_rvalid) begin
              state <= StHalt;
            end else begin
              halt_pending <= 1'b1;
              state        <= StDrop;
            end
          end else if (redirect_take) begin
            pc <= redirect_target;
            if (imem_rvalid) begin
              // The response arriving now is for the old path; drop it and refetch.
              imem_req <= 1'b1;
              state    <= StReq;
            end else begin
              state <= StDrop;
            end
          end else if (imem_rvalid) begin
            instruction_out <= imem_rdata;
            pc_out          <= pc;
            fetch_valid     <= 1'b1;
            state           <= StValid;
          end
        end

        StValid: begin
          if (halted) begin
            fetch_valid     <= 1'b0;
            instruction_out <= 32'h0;
            state           <= StHalt;
          end else if (redirect_take) begin
            pc              <= redirect_target;
            fetch_valid     <= 1'b0;
            instruction_out <= 32'h0;
            imem_req        <= 1'b1;
            state           <= StReq;
          end else if (!stall) begin
            pc              <= pc + 32'd4;
            fetch_valid     <= 1'b0;
            instruction_out <= 32'h0;
            imem_req        <= 1'b1;
            state           <= StReq;
          end
        end

        StDrop: begin
          if (halted) halt_pending <= 1'b1;
          if (redirect_take) pc <= redirect_target;
          if (imem_rvalid) begin
            if (halted || halt_pending) begin
              state <= StHalt;
            end else begin
              imem_req <= 1'b1;
              state    <= StReq;
            end
          end
        end

        StHalt: begin
          // Only reset leaves this state.
          imem_req    <= 1'b0;
          fetch_valid <= 1'b0;
        end

        default: begin
          state    <= StIdle;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding the fetch-to-decode pipeline register. Owns the program counter and issues one instruction-memory request at a time. It handles variable memory latency, branch/jump redirects, back-pressure stall and processor halt. It presents a fetched instruction plus its PC to the downstream register and supplies that register's flush.

## Interface

- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  reset, asynchronous, active-high.
- stall  input  1  downstream hazard stall; the instruction on the outputs is not consumed.
- halted  input  1  processor halt; fetch stops permanently until reset.
- redirect_valid  input  1  taken branch/jump from execute.
- redirect_pc  input  32  redirect target; bits [1:0] ignored and treated as 0.
- imem_req  output  1  request valid to instruction memory.
- imem_addr  output  32  request word address, equal to pc.
- imem_ready  input  1  memory accepts request this cycle when imem_req=1.
- imem_rvalid  input  1  response data valid, exactly one per accepted request.
- imem_rdata  input  32  response instruction.
- instruction_out  output  32  instruction to the downstream register; 32'b0 (NOP) when not valid.
- pc_out  output  32  PC of instruction_out.
- fetch_valid  output  1  instruction_out/pc_out hold a real instruction.
- flush_out  output  1  clears the downstream register; combinationally equal to redirect_valid & ~halted.

## Operation

- States: IDLE, REQ, WAIT, VALID, DROP, HALT. Only one request outstanding at a time.
- IDLE: entered on reset, goes to REQ on the next edge.
- REQ: imem_req=1, imem_addr=pc. On imem_ready go to WAIT.
- WAIT: wait for imem_rvalid. On the response, register imem_rdata into instruction_out, pc into pc_out, set fetch_valid=1, go to VALID.
- VALID: outputs held. If stall=0, the instruction is consumed: pc <= pc+4, fetch_valid <= 0, instruction_out <= 0, go to REQ. If stall=1, hold all outputs unchanged.
- DROP: an accepted request must be discarded. On imem_rvalid, discard the data and go to REQ, or to HALT if a halt is pending.
- HALT: imem_req=0, fetch_valid=0, instruction_out=0. Redirects are ignored. Exit is by reset only.
- Redirect (redirect_valid=1, halted=0) takes priority over stall. It sets pc <= {redirect_pc[31:2],2'b00} and clears fetch_valid and instruction_out. Next state by current state:
  - REQ with no imem_ready: REQ.
  - REQ with imem_ready in the same cycle: DROP.
  - WAIT without imem_rvalid: DROP.
  - WAIT with imem_rvalid in the same cycle: REQ, response discarded.
  - VALID: REQ.
  - DROP: stays DROP with the new pc.
- Halt (halted=1) takes priority over redirect:
  - REQ not accepted, or VALID: go to HALT immediately.
  - REQ accepted that cycle, WAIT, or DROP: set halt_pending and go to DROP; the response is drained, then HALT.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing

- Reset values: pc=RESET_PC, state IDLE, imem_req=0, imem_addr=RESET_PC, instruction_out=0, pc_out=0, fetch_valid=0, halt_pending=0.
- First imem_req is asserted on the first cycle after reset deasserts.
- Zero-wait memory (imem_ready high, rvalid the cycle after acceptance): request at cycle n, fetch_valid=1 at n+2, next request at n+3 if not stalled. Throughput is 1 instruction per 3 cycles.
- Response latency k cycles adds k-1 cycles to the above.
- imem_addr is stable while imem_req=1 and imem_ready=0, unless a redirect occurs.
- flush_out has zero latency, so the downstream register clears on the same edge the redirect is taken.
- Reset mid-transaction abandons any outstanding response. The memory must also be reset.

## Test plan

- Reset with RESET_PC=32'h100, zero-wait memory, stall=0: addresses 0x100, 0x104, 0x108 issued 3 cycles apart; pc_out matches; instruction_out equals memory data.
- stall=1 for 4 cycles while in VALID: instruction_out, pc_out and fetch_valid stay constant, no imem_req; after release the next request is at pc+4.
- Memory latency 5 cycles, redirect to 0x2003 during WAIT: flush_out=1 that cycle, late response discarded (fetch_valid stays 0), next request at 0x2000.
- Redirect in the same cycle as imem_ready: DROP entered, the one response is discarded, then a request to the target.
- halted asserted during WAIT: response drained, then HALT with imem_req=0 forever; a subsequent redirect_valid gives flush_out=0 and no request.
- Redirect to 0xFFFFFFFC, then consumed: next address is 0x00000000.
